// File: rtl/cdb_pkg.sv
// Shared types and helpers for the common-data-bus arbiter: result entry layout,
// default widths and the round-robin pick function.
package cdb_pkg;

    localparam int CDB_FU_COUNT  = 8;
    localparam int CDB_BUF_DEPTH = 2;
    localparam int CDB_DATA_W    = 8;
    localparam int CDB_TAG_W     = 4;
    localparam int CDB_ROBID_W   = 8;
    localparam int CDB_PTR_W     = $clog2(CDB_FU_COUNT);

    typedef struct packed {
        logic [CDB_DATA_W-1:0]  val;
        logic [CDB_TAG_W-1:0]   tag;
        logic [CDB_ROBID_W-1:0] robid;
    } cdb_entry_t;

    // One-hot grant of the first requester at or after ptr, wrapping around.
    function automatic logic [CDB_FU_COUNT-1:0] rr_pick(
        input logic [CDB_FU_COUNT-1:0] req,
        input logic [CDB_PTR_W-1:0]    ptr
    );
        logic [CDB_FU_COUNT-1:0] grant;
        logic [CDB_PTR_W-1:0]    idx;
        logic                    found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < CDB_FU_COUNT; i++) begin
            idx = CDB_PTR_W'((int'(ptr) + i) % CDB_FU_COUNT);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-FU result buffer: DEPTH-entry FIFO of cdb_entry_t with synchronous flush.
// Callers only push when count < DEPTH and only pop when count > 0.
module cdb_result_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = CDB_BUF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  cdb_entry_t       din,
    output cdb_entry_t       head,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    cdb_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers FU results per FU and broadcasts one per cycle.
// Define CDB_ARB_FIXED_PRIO_EN for fixed priority (lowest FU wins); default is round-robin.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int FU_COUNT  = CDB_FU_COUNT,
    parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [FU_COUNT-1:0]                   fu_valid,
    input  logic [FU_COUNT-1:0][CDB_DATA_W-1:0]   fu_val,
    input  logic [FU_COUNT-1:0][CDB_TAG_W-1:0]    fu_tag,
    input  logic [FU_COUNT-1:0][CDB_ROBID_W-1:0]  fu_robid,
    output logic [FU_COUNT-1:0]                   fu_ready,
    output logic                                  cdbtransmit,
    output logic [CDB_DATA_W-1:0]                 cdbval,
    output logic [CDB_TAG_W-1:0]                  cdbid,
    output logic [CDB_ROBID_W-1:0]                cdbrobid
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(FU_COUNT);

    cdb_entry_t          din   [FU_COUNT];
    cdb_entry_t          head  [FU_COUNT];
    logic [CNT_W-1:0]    count [FU_COUNT];
    logic [FU_COUNT-1:0] req;
    logic [FU_COUNT-1:0] push;
    logic [FU_COUNT-1:0] grant;
    cdb_entry_t          win_entry;

    for (genvar k = 0; k < FU_COUNT; k++) begin : g_fu
        assign din[k]      = '{val: fu_val[k], tag: fu_tag[k], robid: fu_robid[k]};
        assign fu_ready[k] = count[k] < CNT_W'(BUF_DEPTH);
        assign req[k]      = count[k] != '0;
        assign push[k]     = fu_valid[k] && fu_ready[k];

        cdb_result_fifo #(.DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .pop   (grant[k]),
            .flush (flush),
            .din   (din[k]),
            .head  (head[k]),
            .count (count[k])
        );
    end

`ifdef CDB_ARB_FIXED_PRIO_EN
    assign grant = req & (~req + FU_COUNT'(1));
`else
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win_idx;

    assign grant = rr_pick(req, rr_ptr);

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < FU_COUNT; k++) begin
            if (grant[k]) win_idx = PTR_W'(k);
        end
    end

    // A flushed grant is not a broadcast, so the pointer holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (!flush && (grant != '0)) begin
            rr_ptr <= (int'(win_idx) == FU_COUNT - 1) ? '0 : win_idx + PTR_W'(1);
        end
    end
`endif

    always_comb begin
        win_entry = '0;
        for (int k = 0; k < FU_COUNT; k++) begin
            if (grant[k]) win_entry = win_entry | head[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdbtransmit <= 1'b0;
            cdbval      <= '0;
            cdbid       <= '0;
            cdbrobid    <= '0;
        end else if (flush || (grant == '0)) begin
            cdbtransmit <= 1'b0;
            cdbval      <= '0;
            cdbid       <= '0;
            cdbrobid    <= '0;
        end else begin
            cdbtransmit <= 1'b1;
            cdbval      <= win_entry.val;
            cdbid       <= win_entry.tag;
            cdbrobid    <= win_entry.robid;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with flushes and a reset.
module tb_cdb_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [7:0]      fu_valid;
    logic [7:0][7:0] fu_val;
    logic [7:0][3:0] fu_tag;
    logic [7:0][7:0] fu_robid;
    logic [7:0]      fu_ready;
    logic            cdbtransmit;
    logic [7:0]      cdbval;
    logic [3:0]      cdbid;
    logic [7:0]      cdbrobid;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fu_valid    (fu_valid),
        .fu_val      (fu_val),
        .fu_tag      (fu_tag),
        .fu_robid    (fu_robid),
        .fu_ready    (fu_ready),
        .cdbtransmit (cdbtransmit),
        .cdbval      (cdbval),
        .cdbid       (cdbid),
        .cdbrobid    (cdbrobid)
    );

    typedef struct packed {
        logic [7:0] v;
        logic [3:0] t;
        logic [7:0] r;
    } ent_t;

    ent_t       mq [8][$];
    int         mptr;
    logic       exp_tx;
    logic [7:0] exp_val;
    logic [3:0] exp_id;
    logic [7:0] exp_rob;
    logic [7:0] acc;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) mq[k].delete();
        mptr    = 0;
        exp_tx  = 1'b0;
        exp_val = '0;
        exp_id  = '0;
        exp_rob = '0;
        acc     = '0;
    endtask

    // One clock: check ready, advance the model across the edge, check the CDB.
    task automatic cycle();
        logic [7:0] mready;
        int         w;
        ent_t       e;
        for (int k = 0; k < 8; k++) mready[k] = (mq[k].size() < 2);
        chk("fu_ready", 32'(fu_ready), 32'(mready));
        w = -1;
        for (int i = 0; i < 8; i++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
            if (w < 0 && mq[i].size() > 0) w = i;
`else
            if (w < 0 && mq[(mptr + i) % 8].size() > 0) w = (mptr + i) % 8;
`endif
        end
        acc = fu_valid & mready;
        if (flush) begin
            for (int k = 0; k < 8; k++) mq[k].delete();
            exp_tx = 0; exp_val = 0; exp_id = 0; exp_rob = 0;
        end else begin
            if (w >= 0) begin
                e       = mq[w].pop_front();
                exp_tx  = 1'b1;
                exp_val = e.v;
                exp_id  = e.t;
                exp_rob = e.r;
                mptr    = (w + 1) % 8;
            end else begin
                exp_tx = 0; exp_val = 0; exp_id = 0; exp_rob = 0;
            end
            for (int k = 0; k < 8; k++)
                if (acc[k]) mq[k].push_back({fu_val[k], fu_tag[k], fu_robid[k]});
        end
        @(posedge clk);
        #1;
        chk("cdbtransmit", 32'(cdbtransmit), 32'(exp_tx));
        chk("cdbval", 32'(cdbval), 32'(exp_val));
        chk("cdbid", 32'(cdbid), 32'(exp_id));
        chk("cdbrobid", 32'(cdbrobid), 32'(exp_rob));
    endtask

    task automatic idle(input int n);
        fu_valid = '0;
        flush    = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        #2;
        rst      = 1'b1;
        fu_valid = '0;
        flush    = 1'b0;
        #1;
        chk("rst_ready", 32'(fu_ready), 32'hFF);
        chk("rst_tx", 32'(cdbtransmit), 32'h0);
        chk("rst_bus", {12'h0, cdbval, cdbid, cdbrobid}, 32'h0);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int         n1;
        int         ntx;
        logic       drop;
        logic [7:0] fu1_seen [$];
        logic [3:0] order [$];

        rst = 1'b1; flush = 1'b0; fu_valid = '0;
        fu_val = '0; fu_tag = '0; fu_robid = '0;
        model_reset();
        #3;
        chk("init_ready", 32'(fu_ready), 32'hFF);
        chk("init_tx", 32'(cdbtransmit), 32'h0);
        #1 rst = 1'b0;

        // FU1 fills while FU0 keeps streaming
        n1 = 0;
        for (int c = 0; c < 40; c++) begin
            fu_valid[0] = (c < 6);
            fu_val[0] = 8'(c); fu_tag[0] = 4'h0; fu_robid[0] = 8'h80 + 8'(c);
            fu_valid[1] = (n1 < 3);
            fu_val[1] = 8'hA0 + 8'(n1); fu_tag[1] = 4'h1; fu_robid[1] = 8'(n1 + 1);
            cycle();
            if (acc[1]) n1++;
            if (c == 1) chk("full_ready1", 32'(fu_ready[1]), 32'h0);
            if (cdbtransmit && cdbid == 4'h1) fu1_seen.push_back(cdbrobid);
        end
        chk("full_pushes", 32'(n1), 32'd3);
        chk("full_bcasts", 32'(fu1_seen.size()), 32'd3);
        for (int i = 0; i < 3 && i < fu1_seen.size(); i++)
            chk("full_order", 32'(fu1_seen[i]), 32'(i + 1));
        idle(3);

        // Single result from FU3
        fu_valid = 8'h08;
        fu_val[3] = 8'h5A; fu_tag[3] = 4'h7; fu_robid[3] = 8'h12;
        cycle();
        chk("single_lat0", 32'(cdbtransmit), 32'h0);
        fu_valid = '0;
        cycle();
        chk("single_tx", 32'(cdbtransmit), 32'h1);
        chk("single_pay", {12'h0, cdbval, cdbid, cdbrobid}, {12'h0, 8'h5A, 4'h7, 8'h12});
        cycle();
        chk("single_off", 32'(cdbtransmit), 32'h0);

        // Round-robin order from a freshly reset pointer
        do_reset();
        fu_valid = 8'b0010_0101;
        for (int k = 0; k < 8; k++) begin
            fu_val[k] = 8'h30 + 8'(k); fu_tag[k] = 4'(k); fu_robid[k] = 8'(k);
        end
        cycle();
        fu_valid = '0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (cdbtransmit) order.push_back(cdbid);
        end
        fu_valid = 8'b0010_0001;
        cycle();
        fu_valid = '0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            if (cdbtransmit) order.push_back(cdbid);
        end
        chk("rr_count", 32'(order.size()), 32'd5);
        if (order.size() == 5) begin
            chk("rr_0", 32'(order[0]), 32'd0);
            chk("rr_1", 32'(order[1]), 32'd2);
            chk("rr_2", 32'(order[2]), 32'd5);
            chk("rr_3", 32'(order[3]), 32'd0);
            chk("rr_4", 32'(order[4]), 32'd5);
        end
        idle(2);

        // Flush with entries buffered and a same-cycle push on FU6
        fu_valid = 8'h0F;
        cycle();
        fu_valid = 8'h40; fu_tag[6] = 4'h6; flush = 1'b1;
        cycle();
        chk("flush_tx", 32'(cdbtransmit), 32'h0);
        fu_valid = '0; flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("flush_quiet", 32'(cdbtransmit), 32'h0);
            chk("flush_ready", 32'(fu_ready), 32'hFF);
        end

        // FU4 streams alone: push and pop every cycle
        ntx = 0; drop = 1'b0;
        for (int i = 0; i < 12; i++) begin
            fu_valid = (i < 10) ? 8'h10 : 8'h00;
            fu_val[4] = 8'(i); fu_tag[4] = 4'h4; fu_robid[4] = 8'(i);
            cycle();
            if (!fu_ready[4]) drop = 1'b1;
            if (cdbtransmit) ntx++;
        end
        chk("stream_bcasts", 32'(ntx), 32'd10);
        chk("stream_ready_drop", 32'(drop), 32'h0);
        idle(2);

        // Random traffic; FUs hold a refused payload until accepted
        acc = '0;
        for (int c = 0; c < 700; c++) begin
            int dens;
            dens = (c < 350) ? 25 : 70;
            flush = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < 8; k++) begin
                if (!(fu_valid[k] && !acc[k])) begin
                    fu_valid[k] = ($urandom_range(0, 99) < dens);
                    fu_val[k]   = 8'($urandom);
                    fu_tag[k]   = 4'($urandom);
                    fu_robid[k] = 8'($urandom);
                end
            end
            cycle();
            if (c == 400) do_reset();
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
